// File: rtl/matmul_pkg.sv
// Shared types and elaboration-time helpers for the NxN matrix multiplier.
package matmul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // Headroom for N full-width products summed into one element.
    function automatic int acc_width(input int data_w, input int n);
        return 2 * data_w + clog2(n);
    endfunction

endpackage

// File: rtl/matmul_mac.sv
// Combinational multiply-add: acc_out = (clr ? 0 : acc_in) + a*b, product extended per SIGNED.
module matmul_mac #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 17,
    parameter int SIGNED = 0
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [ACC_W-1:0]  acc_in,
    input  logic              clr,
    output logic [ACC_W-1:0]  acc_out
);

    logic [ACC_W-1:0] prod_ext;

    generate
        if (SIGNED != 0) begin : g_signed
            logic signed [2*DATA_W-1:0] prod;
            assign prod     = (2*DATA_W)'($signed(a)) * (2*DATA_W)'($signed(b));
            assign prod_ext = ACC_W'(prod);
        end else begin : g_unsigned
            logic [2*DATA_W-1:0] prod;
            assign prod     = (2*DATA_W)'(a) * (2*DATA_W)'(b);
            assign prod_ext = ACC_W'(prod);
        end
    endgenerate

    assign acc_out = (clr ? '0 : acc_in) + prod_ext;

endmodule

// File: rtl/matrix_mul_nxn.sv
// C = A x B over NxN matrices with one shared MAC; done pulses N^3+1 cycles after start.
// Define MATMUL_SAT_EN to clamp each element to the OUT_W range and report it on sat.
module matrix_mul_nxn
    import matmul_pkg::*;
#(
    parameter int N      = 2,
    parameter int DATA_W = 8,
    parameter int OUT_W  = 16,
    parameter int SIGNED = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [N*N*DATA_W-1:0]   a_flat,
    input  logic [N*N*DATA_W-1:0]   b_flat,
    output logic [N*N*OUT_W-1:0]    c_flat,
    output logic                    busy,
    output logic                    done,
    output logic                    sat
);

    localparam int ACC_W = acc_width(DATA_W, N);
    localparam int IDX_W = clog2(N);
    localparam int EL_W  = clog2(N * N);

    typedef logic [IDX_W-1:0] idx_t;
    localparam idx_t LAST = idx_t'(N - 1);

    state_e                       state_q, state_d;
    logic [N*N-1:0][DATA_W-1:0]   a_q, b_q;
    logic [N*N-1:0][OUT_W-1:0]    res_q, res_d, c_q;
    idx_t                         i_q, j_q, k_q;
    logic [ACC_W-1:0]             acc_q, acc_next;
    logic [EL_W-1:0]              a_idx, b_idx, c_idx;
    logic                         k_last, j_last, i_last, mac_last, mac_clr;
    logic [OUT_W-1:0]             conv;

    assign k_last   = (k_q == LAST);
    assign j_last   = (j_q == LAST);
    assign i_last   = (i_q == LAST);
    assign mac_last = (state_q == CALC) && k_last && j_last && i_last;
    assign mac_clr  = (k_q == '0);

    always_comb begin
        a_idx = EL_W'(int'(i_q) * N + int'(k_q));
        b_idx = EL_W'(int'(k_q) * N + int'(j_q));
        c_idx = EL_W'(int'(i_q) * N + int'(j_q));
    end

    matmul_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .SIGNED (SIGNED)
    ) u_mac (
        .a       (a_q[a_idx]),
        .b       (b_q[b_idx]),
        .acc_in  (acc_q),
        .clr     (mac_clr),
        .acc_out (acc_next)
    );

`ifdef MATMUL_SAT_EN
    logic [ACC_W-1:0] back_ext;
    logic             ovf;
    logic             sat_run_q, sat_q;

    // An element overflowed if re-extending its truncated form does not reproduce it.
    always_comb begin
        if (SIGNED != 0) begin
            back_ext = ACC_W'($signed(acc_next[OUT_W-1:0]));
        end else begin
            back_ext = ACC_W'(acc_next[OUT_W-1:0]);
        end
        ovf  = (back_ext != acc_next);
        conv = acc_next[OUT_W-1:0];
        if (ovf) begin
            if (SIGNED != 0) begin
                conv = acc_next[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
            end else begin
                conv = '1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_run_q <= 1'b0;
            sat_q     <= 1'b0;
        end else if (state_q == IDLE && start) begin
            sat_run_q <= 1'b0;
        end else if (state_q == CALC && k_last) begin
            sat_run_q <= sat_run_q | ovf;
            if (mac_last) begin
                sat_q <= sat_run_q | ovf;
            end
        end
    end

    assign sat = sat_q;
`else
    assign conv = acc_next[OUT_W-1:0];
    assign sat  = 1'b0;
`endif

    always_comb begin
        res_d = res_q;
        if (state_q == CALC && k_last) begin
            res_d[c_idx] = conv;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (mac_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == CALC) || (state_q == DONE);
        done = (state_q == DONE);
    end

    // c_q only changes on the final MAC, so c_flat never exposes a partial result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            c_q   <= '0;
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
            acc_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q   <= a_flat;
                        b_q   <= b_flat;
                        i_q   <= '0;
                        j_q   <= '0;
                        k_q   <= '0;
                        acc_q <= '0;
                    end
                end
                CALC: begin
                    res_q <= res_d;
                    if (k_last) begin
                        acc_q <= '0;
                        k_q   <= '0;
                        if (j_last) begin
                            j_q <= '0;
                            i_q <= i_last ? '0 : i_q + idx_t'(1);
                        end else begin
                            j_q <= j_q + idx_t'(1);
                        end
                    end else begin
                        acc_q <= acc_next;
                        k_q   <= k_q + idx_t'(1);
                    end
                    if (mac_last) begin
                        c_q <= res_d;
                    end
                end
                default: ;
            endcase
        end
    end

    assign c_flat = c_q;

endmodule

// File: tb/tb_matrix_mul_nxn.sv
// Scoreboard bench: stimulus pushes expected results, per-instance monitors pop on done.
module tb_matrix_mul_nxn;

    typedef struct {
        logic [143:0] c;
        logic         s;
        int           cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    int            cyc = 0;
    int            checks = 0;
    int            failures = 0;

    logic          start_u2 = 1'b0, start_s2 = 1'b0, start_u3 = 1'b0;
    logic [31:0]   a_u2 = '0, b_u2 = '0, a_s2 = '0, b_s2 = '0;
    logic [71:0]   a_u3 = '0, b_u3 = '0;
    logic [63:0]   c_u2, c_s2;
    logic [143:0]  c_u3;
    logic          busy_u2, done_u2, sat_u2;
    logic          busy_s2, done_s2, sat_s2;
    logic          busy_u3, done_u3, sat_u3;

    exp_t q_u2[$], q_s2[$], q_u3[$];
    exp_t e_u2, e_s2, e_u3;
    int   run_u2 = 0, run_s2 = 0, run_u3 = 0;
    int   done_cnt_u2 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    matrix_mul_nxn #(.N(2), .DATA_W(8), .OUT_W(16), .SIGNED(0)) u_u2 (
        .clk(clk), .rst(rst_n), .start(start_u2), .a_flat(a_u2), .b_flat(b_u2),
        .c_flat(c_u2), .busy(busy_u2), .done(done_u2), .sat(sat_u2));

    matrix_mul_nxn #(.N(2), .DATA_W(8), .OUT_W(16), .SIGNED(1)) u_s2 (
        .clk(clk), .rst(rst_n), .start(start_s2), .a_flat(a_s2), .b_flat(b_s2),
        .c_flat(c_s2), .busy(busy_s2), .done(done_s2), .sat(sat_s2));

    matrix_mul_nxn #(.N(3), .DATA_W(8), .OUT_W(16), .SIGNED(0)) u_u3 (
        .clk(clk), .rst(rst_n), .start(start_u3), .a_flat(a_u3), .b_flat(b_u3),
        .c_flat(c_u3), .busy(busy_u3), .done(done_u3), .sat(sat_u3));

    task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: done pulse with no expected result queued", nm);
    endtask

    function automatic logic [31:0] pk8(input int e0, input int e1, input int e2, input int e3);
        return {8'(e3), 8'(e2), 8'(e1), 8'(e0)};
    endfunction

    function automatic logic [143:0] pk16(input int e0, input int e1, input int e2, input int e3);
        return {80'd0, 16'(e3), 16'(e2), 16'(e1), 16'(e0)};
    endfunction

    // Monitors: compare result, sat, done cycle and busy length on every done pulse.
    always @(negedge clk) begin
        if (busy_u2) run_u2++; else run_u2 = 0;
        if (done_u2) begin
            done_cnt_u2++;
            if (q_u2.size() == 0) unexpected("u2_done");
            else begin
                e_u2 = q_u2.pop_front();
                chk("u2_c", 144'(c_u2), e_u2.c);
                chk("u2_sat", 144'(sat_u2), 144'(e_u2.s));
                chk("u2_done_cycle", 144'(cyc), 144'(e_u2.cyc));
                chk("u2_busy_len", 144'(run_u2), 144'(9));
            end
        end
    end

    always @(negedge clk) begin
        if (busy_s2) run_s2++; else run_s2 = 0;
        if (done_s2) begin
            if (q_s2.size() == 0) unexpected("s2_done");
            else begin
                e_s2 = q_s2.pop_front();
                chk("s2_c", 144'(c_s2), e_s2.c);
                chk("s2_sat", 144'(sat_s2), 144'(e_s2.s));
                chk("s2_done_cycle", 144'(cyc), 144'(e_s2.cyc));
                chk("s2_busy_len", 144'(run_s2), 144'(9));
            end
        end
    end

    always @(negedge clk) begin
        if (busy_u3) run_u3++; else run_u3 = 0;
        if (done_u3) begin
            if (q_u3.size() == 0) unexpected("u3_done");
            else begin
                e_u3 = q_u3.pop_front();
                chk("u3_c", c_u3, e_u3.c);
                chk("u3_sat", 144'(sat_u3), 144'(e_u3.s));
                chk("u3_done_cycle", 144'(cyc), 144'(e_u3.cyc));
                chk("u3_busy_len", 144'(run_u3), 144'(28));
            end
        end
    end

    task automatic go_u2(input logic [31:0] a, input logic [31:0] b,
                         input logic [143:0] c, input logic s);
        exp_t e;
        @(negedge clk);
        a_u2 = a; b_u2 = b; start_u2 = 1'b1;
        e.c = c; e.s = s; e.cyc = cyc + 1 + 8;
        q_u2.push_back(e);
        @(negedge clk);
        start_u2 = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 400; t++) begin
            if (q_u2.size() == 0 && q_s2.size() == 0 && q_u3.size() == 0) break;
            @(negedge clk);
        end
        if (q_u2.size() != 0 || q_s2.size() != 0 || q_u3.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: pending u2=%0d s2=%0d u3=%0d required 0",
                     q_u2.size(), q_s2.size(), q_u3.size());
            q_u2.delete(); q_s2.delete(); q_u3.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [143:0] c255;
        logic         s255;
        logic [143:0] c_mix;
        exp_t         e;
        int           dc;

`ifdef MATMUL_SAT_EN
        c255 = pk16(65535, 65535, 65535, 65535);
        s255 = 1'b1;
`else
        c255 = pk16(64514, 64514, 64514, 64514);
        s255 = 1'b0;
`endif
        c_mix = pk16(19, 22, 43, 50);

        repeat (3) @(negedge clk);
        chk("rst_busy", 144'(busy_u2), 144'(0));
        chk("rst_done", 144'(done_u2), 144'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_c_u2", 144'(c_u2), 144'(0));
        chk("rst_sat_u2", 144'(sat_u2), 144'(0));
        chk("rst_c_u3", c_u3, 144'(0));
        chk("rst_busy_u3", 144'(busy_u3), 144'(0));

        go_u2(pk8(1, 2, 3, 4), pk8(1, 0, 0, 1), pk16(1, 2, 3, 4), 1'b0);
        drain();
        go_u2(pk8(1, 2, 3, 4), pk8(5, 6, 7, 8), c_mix, 1'b0);
        drain();
        go_u2(pk8(255, 255, 255, 255), pk8(255, 255, 255, 255), c255, s255);
        drain();

        // Restart and operand changes mid-CALC must not disturb the running job.
        go_u2(pk8(1, 2, 3, 4), pk8(5, 6, 7, 8), c_mix, 1'b0);
        repeat (2) @(negedge clk);
        chk("u2_hold_c", 144'(c_u2), c255);
        chk("u2_hold_sat", 144'(sat_u2), 144'(s255));
        a_u2 = pk8(9, 9, 9, 9); b_u2 = pk8(7, 7, 7, 7); start_u2 = 1'b1;
        @(negedge clk);
        start_u2 = 1'b0;
        drain();

        // start held high: two jobs separated by one IDLE cycle.
        @(negedge clk);
        a_u2 = pk8(1, 2, 3, 4); b_u2 = pk8(5, 6, 7, 8); start_u2 = 1'b1;
        e.c = c_mix; e.s = 1'b0; e.cyc = cyc + 1 + 8;
        q_u2.push_back(e);
        e.cyc = e.cyc + 10;
        q_u2.push_back(e);
        repeat (12) @(negedge clk);
        start_u2 = 1'b0;
        drain();

        @(negedge clk);
        a_s2 = pk8(-1, 2, 3, -4); b_s2 = pk8(5, -6, 7, 8); start_s2 = 1'b1;
        e.c = pk16(9, 22, -13, -50); e.s = 1'b0; e.cyc = cyc + 1 + 8;
        q_s2.push_back(e);
        @(negedge clk);
        start_s2 = 1'b0;
        drain();

        @(negedge clk);
        a_u3 = '0; b_u3 = '0; e.c = '0;
        for (int i = 0; i < 9; i++) begin
            a_u3[i*8 +: 8]  = 8'(i + 1);
            e.c[i*16 +: 16] = 16'(i + 1);
        end
        for (int i = 0; i < 3; i++) b_u3[(i*3 + i)*8 +: 8] = 8'd1;
        start_u3 = 1'b1;
        e.s = 1'b0; e.cyc = cyc + 1 + 27;
        q_u3.push_back(e);
        @(negedge clk);
        start_u3 = 1'b0;
        drain();

        // Abort during CALC: no done, outputs cleared, fresh run still correct.
        go_u2(pk8(1, 2, 3, 4), pk8(5, 6, 7, 8), c_mix, 1'b0);
        repeat (3) @(negedge clk);
        q_u2.delete();
        rst_n = 1'b0;
        #1;
        chk("abort_c", 144'(c_u2), 144'(0));
        chk("abort_busy", 144'(busy_u2), 144'(0));
        @(negedge clk);
        rst_n = 1'b1;
        dc = done_cnt_u2;
        repeat (20) @(negedge clk);
        chk("abort_no_done", 144'(done_cnt_u2), 144'(dc));
        chk("abort_idle", 144'(busy_u2), 144'(0));
        chk("abort_c_hold", 144'(c_u2), 144'(0));
        go_u2(pk8(1, 2, 3, 4), pk8(5, 6, 7, 8), c_mix, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
